// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, client indices, colors and FSM encoding for the
// draw scheduler and its arbiter.
package fb_pkg;

    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;
    localparam int FB_AW     = 15;
    localparam int FB_DW     = 3;
    localparam int FB_NCLI   = 3;

    localparam int COORD_XW = 8;
    localparam int COORD_YW = 7;

    localparam int CLIENT_CLEAR   = 0;
    localparam int CLIENT_PADDLES = 1;
    localparam int CLIENT_BALL    = 2;

    localparam logic [FB_DW-1:0] COLOR_OBJECT = 3'b111;
    localparam logic [FB_DW-1:0] COLOR_SCREEN = 3'b000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LATCH  = 2'd1,
        DRAW   = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Width of a client index, kept at least one bit for the single-client case.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_draw_scheduler_if.sv
// Client request bus plus frame-buffer write port seen by the draw scheduler.
interface fb_draw_scheduler_if #(
    parameter int NCLI = fb_pkg::FB_NCLI,
    parameter int AW   = fb_pkg::FB_AW,
    parameter int DW   = fb_pkg::FB_DW
);
    import fb_pkg::*;

    logic [NCLI-1:0]          req;
    logic [NCLI*COORD_XW-1:0] req_x;
    logic [NCLI*COORD_YW-1:0] req_y;
    logic [NCLI*COORD_XW-1:0] req_w;
    logic [NCLI*COORD_YW-1:0] req_h;
    logic [NCLI*DW-1:0]       req_color;
    logic [NCLI-1:0]          done;
    logic                     busy;
    logic [AW-1:0]            mem_px_addr;
    logic [DW-1:0]            mem_px_data;
    logic                     px_wr;

    modport master (
        output req, req_x, req_y, req_w, req_h, req_color,
        input  done, busy, mem_px_addr, mem_px_data, px_wr
    );

    modport slave (
        input  req, req_x, req_y, req_w, req_h, req_color,
        output done, busy, mem_px_addr, mem_px_data, px_wr
    );

endinterface

// File: rtl/fb_draw_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from the client after the last accepted grant.
module rr_arbiter
    import fb_pkg::*;
#(
    parameter int NCLI = FB_NCLI,
    localparam int IW  = idx_width(NCLI)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCLI-1:0] req,
    input  logic            accept,
    output logic [NCLI-1:0] grant,
    output logic [IW-1:0]   grant_idx
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand_idx;
    logic          found;
    int            cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NCLI; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NCLI) cand = cand - NCLI;
            cand_idx = IW'(cand);
            if (!found && req[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
                found           = 1'b1;
            end
        end
        ptr_d = (accept && found) ? grant_idx : ptr_q;
    end

    // Pointer resets to the last client so client 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= IW'(NCLI - 1);
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fb_draw_scheduler.sv
// Serialises client rectangle fills into one-pixel-per-cycle frame-buffer writes,
// clipping each rectangle to the frame before drawing.
module fb_draw_scheduler
    import fb_pkg::*;
#(
    parameter int WIDTH  = FB_WIDTH,
    parameter int HEIGHT = FB_HEIGHT,
    parameter int AW     = FB_AW,
    parameter int DW     = FB_DW,
    parameter int NCLI   = FB_NCLI
) (
    input  logic                clk,
    input  logic                rst,
    fb_draw_scheduler_if.slave  bus
);

    localparam int IW = idx_width(NCLI);

    state_t                 state_q, state_d;
    logic [NCLI-1:0]        grant_q, grant_d;
    logic [IW-1:0]          grant_idx_q, grant_idx_d;
    logic [COORD_XW-1:0]    w_q, w_d, col_q, col_d;
    logic [COORD_YW-1:0]    h_q, h_d, row_q, row_d;
    logic [AW-1:0]          row_base_q, row_base_d, addr_q, addr_d;
    logic [DW-1:0]          data_q, data_d;
    logic                   px_wr_q, px_wr_d, busy_q, busy_d;
    logic [NCLI-1:0]        done_q, done_d;

    logic                   accept;
    logic [NCLI-1:0]        arb_grant;
    logic [IW-1:0]          arb_idx;
    logic [COORD_XW-1:0]    sel_x, sel_w, room_x, w_eff;
    logic [COORD_YW-1:0]    sel_y, sel_h, room_y, h_eff;
    logic [DW-1:0]          sel_color;
    logic [AW-1:0]          base;
    logic                   outside;

    rr_arbiter #(.NCLI(NCLI)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req),
        .accept    (accept),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign sel_x     = bus.req_x[grant_idx_q*COORD_XW +: COORD_XW];
    assign sel_y     = bus.req_y[grant_idx_q*COORD_YW +: COORD_YW];
    assign sel_w     = bus.req_w[grant_idx_q*COORD_XW +: COORD_XW];
    assign sel_h     = bus.req_h[grant_idx_q*COORD_YW +: COORD_YW];
    assign sel_color = bus.req_color[grant_idx_q*DW +: DW];

    // Clipping and the start address are only needed once per rectangle, in LATCH.
    assign outside = (int'(sel_x) >= WIDTH) || (int'(sel_y) >= HEIGHT);
    assign room_x  = COORD_XW'(WIDTH - int'(sel_x));
    assign room_y  = COORD_YW'(HEIGHT - int'(sel_y));
    assign w_eff   = outside ? '0 : ((sel_w > room_x) ? room_x : sel_w);
    assign h_eff   = outside ? '0 : ((sel_h > room_y) ? room_y : sel_h);
    assign base    = AW'(int'(sel_y) * WIDTH + int'(sel_x));

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        w_d         = w_q;
        h_d         = h_q;
        col_d       = col_q;
        row_d       = row_q;
        row_base_d  = row_base_q;
        addr_d      = addr_q;
        data_d      = data_q;
        px_wr_d     = 1'b0;
        done_d      = '0;
        busy_d      = busy_q;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    accept      = 1'b1;
                    grant_d     = arb_grant;
                    grant_idx_d = arb_idx;
                    busy_d      = 1'b1;
                    state_d     = LATCH;
                end
            end
            LATCH: begin
                w_d        = w_eff;
                h_d        = h_eff;
                col_d      = '0;
                row_d      = '0;
                row_base_d = base;
                if (w_eff != '0 && h_eff != '0) begin
                    px_wr_d = 1'b1;
                    addr_d  = base;
                    data_d  = sel_color;
                    state_d = DRAW;
                end else begin
                    done_d  = grant_q;
                    state_d = FINISH;
                end
            end
            DRAW: begin
                // Row steps add WIDTH to the row base; no per-pixel multiply.
                if (col_q == w_q - COORD_XW'(1)) begin
                    if (row_q == h_q - COORD_YW'(1)) begin
                        done_d  = grant_q;
                        state_d = FINISH;
                    end else begin
                        col_d      = '0;
                        row_d      = row_q + COORD_YW'(1);
                        row_base_d = row_base_q + AW'(WIDTH);
                        addr_d     = row_base_q + AW'(WIDTH);
                        px_wr_d    = 1'b1;
                    end
                end else begin
                    col_d   = col_q + COORD_XW'(1);
                    addr_d  = addr_q + AW'(1);
                    px_wr_d = 1'b1;
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            w_q         <= '0;
            h_q         <= '0;
            col_q       <= '0;
            row_q       <= '0;
            row_base_q  <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            px_wr_q     <= 1'b0;
            done_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            w_q         <= w_d;
            h_q         <= h_d;
            col_q       <= col_d;
            row_q       <= row_d;
            row_base_q  <= row_base_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            px_wr_q     <= px_wr_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.px_wr       = px_wr_q;
    assign bus.mem_px_addr = addr_q;
    assign bus.mem_px_data = data_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;

endmodule
